// File: rtl/skin_seg_pkg.sv
// Shared encodings and default thresholds for the skin/hand segmentation stage.
package skin_seg_pkg;

  // Segmentation mode encoding; the reserved code 3 behaves as chroma mode.
  localparam logic [1:0] MODE_CHROMA = 2'd0;
  localparam logic [1:0] MODE_BG     = 2'd1;
  localparam logic [1:0] MODE_ADAPT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEGMENT = 2'd2
  } seg_state_e;

  // Default chroma window (exclusive bounds) and luma difference threshold.
  localparam int DEF_Y_MIN    = 80;
  localparam int DEF_CB_MIN   = 125;
  localparam int DEF_CB_MAX   = 180;
  localparam int DEF_CR_MIN   = 190;
  localparam int DEF_CR_MAX   = 225;
  localparam int DEF_DIFF_THR = 40;

  // Fold the reserved mode code onto chroma so downstream logic sees only 0..2.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_CHROMA : m;
  endfunction

endpackage

// File: rtl/bg_frame_ram.sv
// Background luma frame store: one synchronous read port, one write port.
module bg_frame_ram #(
  parameter int PIX_W  = 8,
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_data_q;

  // Registered read and write; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/skin_segmenter.sv
// YCbCr stream to 1-bit object mask: chroma window, background difference,
// or background difference with running-average background update.
module skin_segmenter
  import skin_seg_pkg::*;
#(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 19200,
  parameter int ADDR_W       = 15,
  parameter int ALPHA_SHIFT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] luma,
  input  logic [PIX_W-1:0] cb,
  input  logic [PIX_W-1:0] cr,
  input  logic [1:0]       mode,
  input  logic             capture_bg,
  input  logic [PIX_W-1:0] y_min,
  input  logic [PIX_W-1:0] cb_min,
  input  logic [PIX_W-1:0] cb_max,
  input  logic [PIX_W-1:0] cr_min,
  input  logic [PIX_W-1:0] cr_max,
  input  logic [PIX_W-1:0] diff_thr,
  output logic             mask_valid,
  output logic             mask,
  output logic             mask_sof,
  output logic             bg_ready,
  output logic             frame_err
);

  // One extra counter bit so pixels past the frame end stay distinguishable.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);

  seg_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pending_q, pending_d, bg_ready_q, bg_ready_d;
  logic [1:0] active_mode_q, active_mode_d;

  // Stage-1 pipeline registers.
  logic s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_cap_q, s1_cap_d;
  logic s1_seg_q, s1_seg_d, s1_last_q, s1_last_d, s1_err_q, s1_err_d;
  logic s1_in_range_q, s1_in_range_d;
  logic [1:0] s1_mode_q, s1_mode_d;
  logic [PIX_W-1:0] s1_luma_q, s1_luma_d, s1_cb_q, s1_cb_d, s1_cr_q, s1_cr_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

  // Stage-2 output registers.
  logic mask_valid_q, mask_valid_d, mask_q, mask_d;
  logic mask_sof_q, mask_sof_d, frame_err_q, frame_err_d;

  logic [CNT_W-1:0] pix_idx;
  logic in_range, pix_last, pix_cap, pix_seg;
  logic [PIX_W-1:0] bg_rd, wr_data;
  logic wr_en, cap_wr, adapt_wr, seg_live, chroma_hit, diff_hit;
  logic [PIX_W:0] abs_diff;
  logic signed [PIX_W:0] sdiff, step;

  // Position of the incoming pixel within its frame.
  always_comb begin
    pix_idx  = pix_sof ? '0 : cnt_q;
    in_range = pix_idx < FRAME_LEN;
    pix_last = pix_idx == LAST_IDX;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a pending capture wins at sof; capture ends on the last pixel.
  always_comb begin
    state_d = state_q;
    if (pix_valid) begin
      if (pix_sof) begin
        if (pending_q)               state_d = ST_CAPTURE;
        else if (state_q == ST_IDLE) state_d = ST_SEGMENT;
      end else if (state_q == ST_CAPTURE && pix_last) begin
        state_d = ST_SEGMENT;
      end
    end
  end

  // FSM outputs: classify the incoming pixel as capture or segmentation work.
  always_comb begin
    pix_cap = pix_valid && ((pix_sof && pending_q) || state_q == ST_CAPTURE);
    pix_seg = pix_valid && !pix_cap && (state_q == ST_SEGMENT || pix_sof);
  end

  // Stage 1 control and data capture.
  always_comb begin
    cnt_d         = cnt_q;
    active_mode_d = active_mode_q;
    if (pix_valid) begin
      cnt_d = (pix_idx == '1) ? pix_idx : pix_idx + 1'b1;
      if (pix_sof) active_mode_d = norm_mode(mode);
    end
    pending_d     = (pending_q && !(pix_valid && pix_sof)) || capture_bg;
    s1_valid_d    = pix_valid;
    s1_sof_d      = pix_valid && pix_sof;
    s1_cap_d      = pix_cap;
    s1_seg_d      = pix_seg;
    s1_last_d     = pix_last;
    s1_in_range_d = in_range;
    s1_mode_d     = pix_sof ? norm_mode(mode) : active_mode_q;
    s1_luma_d     = luma;
    s1_cb_d       = cb;
    s1_cr_d       = cr;
    s1_addr_d     = pix_idx[ADDR_W-1:0];
    // Short frame flagged at the early sof; long frame at the first extra pixel.
    s1_err_d = pix_valid && state_q != ST_IDLE &&
               ((pix_sof && cnt_q < FRAME_LEN) || (!pix_sof && pix_idx == FRAME_LEN));
  end

  bg_frame_ram #(.PIX_W(PIX_W), .DEPTH(FRAME_PIXELS), .ADDR_W(ADDR_W)) u_bg_ram (
    .clk     (clk),
    .rd_en   (pix_seg && in_range),
    .rd_addr (pix_idx[ADDR_W-1:0]),
    .rd_data (bg_rd),
    .wr_en   (wr_en),
    .wr_addr (s1_addr_q),
    .wr_data (wr_data)
  );

  // Stage 2: classify the pixel and form the background write-back.
  always_comb begin
    chroma_hit = (s1_luma_q > y_min) && (s1_cb_q > cb_min) && (s1_cb_q < cb_max) &&
                 (s1_cr_q > cr_min) && (s1_cr_q < cr_max);
    abs_diff   = (s1_luma_q >= bg_rd) ? ({1'b0, s1_luma_q} - {1'b0, bg_rd})
                                      : ({1'b0, bg_rd} - {1'b0, s1_luma_q});
    diff_hit   = abs_diff > {1'b0, diff_thr};
    sdiff      = $signed({1'b0, s1_luma_q}) - $signed({1'b0, bg_rd});
    step       = sdiff >>> ALPHA_SHIFT;
    seg_live   = s1_valid_q && s1_seg_q && s1_in_range_q;
    mask_d     = seg_live && ((s1_mode_q == MODE_CHROMA) ? chroma_hit
                                                         : (bg_ready_q && diff_hit));
    adapt_wr   = seg_live && s1_mode_q == MODE_ADAPT && bg_ready_q && !diff_hit;
    cap_wr     = s1_valid_q && s1_cap_q && s1_in_range_q;
    wr_en      = cap_wr || adapt_wr;
    // The updated value lies between bg and luma, so truncation never loses data.
    wr_data    = cap_wr ? s1_luma_q : PIX_W'({1'b0, bg_rd} + $unsigned(step));
    mask_valid_d = s1_valid_q;
    mask_sof_d   = s1_sof_q;
    frame_err_d  = s1_valid_q && s1_err_q;
    bg_ready_d   = bg_ready_q;
    if (pix_valid && pix_sof && pending_q) bg_ready_d = 1'b0;
    else if (cap_wr && s1_last_q)          bg_ready_d = 1'b1;
  end

  // Register all pipeline and control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0; pending_q <= 1'b0; bg_ready_q <= 1'b0; active_mode_q <= MODE_CHROMA;
      s1_valid_q <= 1'b0; s1_sof_q <= 1'b0; s1_cap_q <= 1'b0; s1_seg_q <= 1'b0;
      s1_last_q <= 1'b0; s1_err_q <= 1'b0; s1_in_range_q <= 1'b0; s1_mode_q <= MODE_CHROMA;
      s1_luma_q <= '0; s1_cb_q <= '0; s1_cr_q <= '0; s1_addr_q <= '0;
      mask_valid_q <= 1'b0; mask_q <= 1'b0; mask_sof_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d; pending_q <= pending_d; bg_ready_q <= bg_ready_d;
      active_mode_q <= active_mode_d;
      s1_valid_q <= s1_valid_d; s1_sof_q <= s1_sof_d; s1_cap_q <= s1_cap_d;
      s1_seg_q <= s1_seg_d; s1_last_q <= s1_last_d; s1_err_q <= s1_err_d;
      s1_in_range_q <= s1_in_range_d; s1_mode_q <= s1_mode_d;
      s1_luma_q <= s1_luma_d; s1_cb_q <= s1_cb_d; s1_cr_q <= s1_cr_d; s1_addr_q <= s1_addr_d;
      mask_valid_q <= mask_valid_d; mask_q <= mask_d; mask_sof_q <= mask_sof_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign mask_valid = mask_valid_q;
  assign mask       = mask_q;
  assign mask_sof   = mask_sof_q;
  assign bg_ready   = bg_ready_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_skin_segmenter.sv
// Self-checking bench: directed scenarios plus randomized frames, checked
// pixel-by-pixel against a per-pixel behavioural model of the segmenter.
module tb_skin_segmenter;
  import skin_seg_pkg::*;

  localparam int PW = 8;
  localparam int FP = 16;
  localparam int AW = 4;
  localparam int AS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_valid = 1'b0, pix_sof = 1'b0, capture_bg = 1'b0;
  logic [PW-1:0] luma = '0, cb = '0, cr = '0;
  logic [1:0] mode = 2'd0;
  logic [PW-1:0] y_min, cb_min, cb_max, cr_min, cr_max, diff_thr;
  logic mask_valid, mask, mask_sof, bg_ready, frame_err;

  always #5 clk = ~clk;

  skin_segmenter #(.PIX_W(PW), .FRAME_PIXELS(FP), .ADDR_W(AW), .ALPHA_SHIFT(AS)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .luma(luma), .cb(cb), .cr(cr), .mode(mode), .capture_bg(capture_bg),
    .y_min(y_min), .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .diff_thr(diff_thr), .mask_valid(mask_valid), .mask(mask), .mask_sof(mask_sof),
    .bg_ready(bg_ready), .frame_err(frame_err)
  );

  int compared = 0;
  int mismatched = 0;
  int frame_no = 0;
  bit gaps = 0;

  // Reference model state: phase 0 idle, 1 capturing, 2 segmenting.
  int m_phase = 0, m_cnt = 0, m_mode = 0;
  bit m_pending = 0, m_ready = 0;
  logic [PW-1:0] m_bg [FP];

  typedef struct packed { bit v; bit m; bit s; bit e; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected result of one input cycle, applying the rules directly per pixel.
  task automatic model(input bit v, input bit s, input logic [PW-1:0] y, c_b, c_r,
                       input logic [1:0] md, output bit m, output bit e);
    int idx, d, ad;
    m = 0; e = 0;
    if (!v) return;
    if (s) begin
      if (m_phase != 0 && m_cnt < FP) e = 1;
      idx = 0;
      m_mode = (md == 2'd3) ? 0 : int'(md);
      if (m_pending) begin m_pending = 0; m_phase = 1; m_ready = 0; end
      else if (m_phase == 0) m_phase = 2;
    end else begin
      idx = m_cnt;
      if (m_phase != 0 && idx == FP) e = 1;
    end
    m_cnt = idx + 1;
    if (idx >= FP || m_phase == 0) return;
    if (m_phase == 1) begin
      m_bg[idx] = y;
      if (idx == FP - 1) begin m_ready = 1; m_phase = 2; end
      return;
    end
    if (m_mode == 0) begin
      m = (y > y_min) && (c_b > cb_min) && (c_b < cb_max) && (c_r > cr_min) && (c_r < cr_max);
    end else if (m_ready) begin
      d  = int'(y) - int'(m_bg[idx]);
      ad = (d < 0) ? -d : d;
      m  = ad > int'(diff_thr);
      if (m_mode == 2 && !m) m_bg[idx] = PW'(int'(m_bg[idx]) + (d >>> AS));
    end
  endtask

  // Drive one cycle, then check the outputs belonging to the previous cycle.
  task automatic step(input bit v, input bit s, input logic [PW-1:0] y, c_b, c_r,
                      input logic [1:0] md, input bit cap);
    bit em, ee;
    exp_t e;
    pix_valid = v; pix_sof = s; luma = y; cb = c_b; cr = c_r; mode = md; capture_bg = cap;
    model(v, s, y, c_b, c_r, md, em, ee);
    if (cap) m_pending = 1;
    exp_q.push_back('{v: v, m: em, s: v & s, e: ee});
    @(posedge clk); #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk("mask_valid", 32'(mask_valid), 32'(e.v));
      chk("mask", 32'(mask), 32'(e.m));
      chk("mask_sof", 32'(mask_sof), 32'(e.s));
      chk("frame_err", 32'(frame_err), 32'(e.e));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, mode, 0);
  endtask

  task automatic pulse_capture();
    step(0, 0, '0, '0, '0, mode, 1);
  endtask

  // One frame: kind 0 flat luma, 1 random luma, 2 luma cycling yv-1, yv, yv+1.
  // Non-sof pixels carry a random mode to show it is only sampled at sof.
  task automatic frame(input int n, input logic [1:0] md, input int kind, input logic [PW-1:0] yv);
    logic [PW-1:0] y;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) idle(1);
      case (kind)
        0:       y = yv;
        1:       y = PW'($urandom);
        default: y = yv - 8'd1 + PW'(i % 3);
      endcase
      step(1, i == 0, y, PW'($urandom_range(110, 195)), PW'($urandom_range(180, 235)),
           (i == 0) ? md : 2'($urandom), 0);
    end
    idle(3);
    chk("bg_ready", 32'(bg_ready), 32'(m_ready));
    frame_no++;
    $display("frame %0d: mode=%0d pixels=%0d bg_ready=%0b model_bg0=%0d", frame_no, md, n,
             bg_ready, m_bg[0]);
  endtask

  initial begin
    y_min = PW'(DEF_Y_MIN); cb_min = PW'(DEF_CB_MIN); cb_max = PW'(DEF_CB_MAX);
    cr_min = PW'(DEF_CR_MIN); cr_max = PW'(DEF_CR_MAX); diff_thr = PW'(DEF_DIFF_THR);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mask_valid", 32'(mask_valid), 0);
    chk("rst_mask", 32'(mask), 0);
    chk("rst_mask_sof", 32'(mask_sof), 0);
    chk("rst_bg_ready", 32'(bg_ready), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    idle(2);

    // Chroma window: inside, then cr above the window.
    step(1, 1, 8'd100, 8'd150, 8'd200, 2'd0, 0);
    step(1, 0, 8'd100, 8'd150, 8'd230, 2'd0, 0);
    for (int i = 2; i < FP; i++)
      step(1, 0, PW'($urandom_range(60, 120)), PW'($urandom_range(110, 195)),
           PW'($urandom_range(180, 235)), 2'd1, 0);
    idle(3);
    $display("frame chroma-directed done");
    frame(FP, 2'd3, 1, 0);

    // Capture flat 50, then background difference frames.
    pulse_capture();
    frame(FP, 2'd0, 0, 8'd50);
    frame(FP, 2'd1, 0, 8'd95);
    frame(FP, 2'd1, 0, 8'd20);

    // Reversed sign: bg above luma.
    pulse_capture();
    frame(FP, 2'd0, 0, 8'd200);
    frame(FP, 2'd1, 0, 8'd10);

    // Adaptive update from bg=80 towards luma=160, then probe bg with diff_thr=0.
    pulse_capture();
    frame(FP, 2'd0, 0, 8'd80);
    diff_thr = 8'd200;
    repeat (3) frame(FP, 2'd2, 0, 8'd160);
    diff_thr = 8'd0;
    frame(FP, 2'd1, 2, m_bg[0]);

    // Short frame during capture, then a full frame completes it.
    diff_thr = PW'(DEF_DIFF_THR);
    pulse_capture();
    frame(5, 2'd1, 0, 8'd70);
    frame(FP, 2'd1, 1, 0);
    frame(FP, 2'd1, 1, 0);

    // Overlong frame.
    frame(FP + 5, 2'd1, 1, 0);
    frame(FP, 2'd2, 1, 0);

    // Randomized frames with gaps, random thresholds and occasional recapture.
    gaps = 1;
    for (int r = 0; r < 14; r++) begin
      y_min = PW'($urandom_range(40, 120)); diff_thr = PW'($urandom_range(0, 90));
      cb_min = PW'($urandom_range(110, 140)); cb_max = PW'($urandom_range(160, 195));
      cr_min = PW'($urandom_range(180, 200)); cr_max = PW'($urandom_range(210, 235));
      if ($urandom_range(3) == 0) pulse_capture();
      frame(($urandom_range(4) == 0) ? int'($urandom_range(2, FP - 1)) : FP,
            2'($urandom), 1, 0);
    end
    gaps = 0;

    // Reset in the middle of a segmenting frame.
    diff_thr = PW'(DEF_DIFF_THR);
    for (int i = 0; i < 6; i++) step(1, i == 0, PW'($urandom), 8'd150, 8'd200, 2'd1, 0);
    rst = 1'b1;
    #1;
    chk("midrst_mask_valid", 32'(mask_valid), 0);
    chk("midrst_mask", 32'(mask), 0);
    chk("midrst_mask_sof", 32'(mask_sof), 0);
    chk("midrst_bg_ready", 32'(bg_ready), 0);
    chk("midrst_frame_err", 32'(frame_err), 0);
    exp_q.delete();
    m_phase = 0; m_cnt = 0; m_mode = 0; m_pending = 0; m_ready = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 6; i < FP; i++) step(1, 0, PW'($urandom), 8'd150, 8'd200, 2'd1, 0);
    idle(3);
    frame(FP, 2'd1, 1, 0);
    pulse_capture();
    frame(FP, 2'd0, 1, 0);
    frame(FP, 2'd1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
